// File: rtl/scene_compositor.sv
// scene_compositor: priority layer compositor with splash/play/game-over phase sequencer
//   clk, clr (async active-high reset)
//   video_on, layer_on, rgb_pic, layer_en : pixel inputs, composited into rgb one cycle later
//   start, restart, game_over             : phase control
//   rgb, game_begin, game_over_display, bg_sel, phase : registered outputs
module scene_compositor #(
  parameter int                  LAYERS          = 5,
  parameter int                  COLOR_W         = 12,
  parameter logic [COLOR_W-1:0]  KEY_COLOR       = 12'hF0F,
  parameter logic [COLOR_W-1:0]  BG_COLOR        = '0,
  parameter logic [LAYERS-1:0]   PLAY_ONLY_MASK  = 5'b00001,
  parameter int unsigned         SPLASH_CYCLES   = 500_000_000,
  parameter int unsigned         GAMEOVER_CYCLES = 5_000
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        video_on,
  input  logic [LAYERS-1:0]           layer_on,
  input  logic [LAYERS*COLOR_W-1:0]   rgb_pic,
  input  logic [LAYERS-1:0]           layer_en,
  input  logic                        start,
  input  logic                        restart,
  input  logic                        game_over,
  output logic [COLOR_W-1:0]          rgb,
  output logic                        game_begin,
  output logic                        game_over_display,
  output logic [1:0]                  bg_sel,
  output logic [1:0]                  phase
);
  typedef enum logic [1:0] {SPLASH = 2'd0, PLAY = 2'd1, OVER_WAIT = 2'd2, OVER_SHOW = 2'd3} phase_t;
  phase_t             r_phase, w_next;
  logic [31:0]        r_timer, w_timer_next;
  logic [COLOR_W-1:0] r_pix, w_pix;
  logic               r_video, r_game_begin, r_over_disp, w_play_vis;
  logic [1:0]         r_bg_sel;
  // Timer only runs in the two dwell states; every transition leaves it at 0.
  always_comb begin
    w_next = r_phase;
    w_timer_next = '0;
    if (restart) w_next = SPLASH;
    else
      case (r_phase)
        SPLASH:    if (start || r_timer == SPLASH_CYCLES - 1) w_next = PLAY;
                   else w_timer_next = r_timer + 32'd1;
        PLAY:      if (game_over) w_next = OVER_WAIT;
        OVER_WAIT: if (r_timer == GAMEOVER_CYCLES - 1) w_next = OVER_SHOW;
                   else w_timer_next = r_timer + 32'd1;
        default:   w_next = OVER_SHOW;
      endcase
  end
  // Ascending scan so the highest-index eligible layer overrides the rest.
  always_comb begin
    w_play_vis = r_phase == PLAY || r_phase == OVER_WAIT;
    w_pix = BG_COLOR;
    for (int i = 0; i < LAYERS; i++)
      if (layer_on[i] && layer_en[i] && rgb_pic[i*COLOR_W +: COLOR_W] != KEY_COLOR &&
          (!PLAY_ONLY_MASK[i] || w_play_vis))
        w_pix = rgb_pic[i*COLOR_W +: COLOR_W];
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_phase <= SPLASH;
      r_timer <= '0;
      r_pix <= '0;
      r_video <= 1'b0;
      r_game_begin <= 1'b0;
      r_over_disp <= 1'b0;
      r_bg_sel <= 2'd0;
    end else begin
      r_phase <= w_next;
      r_timer <= w_timer_next;
      r_pix <= w_pix;
      r_video <= video_on;
      r_game_begin <= w_next != SPLASH;
      r_over_disp <= w_next == OVER_SHOW;
      r_bg_sel <= w_next == OVER_SHOW ? 2'd2 : w_next == SPLASH ? 2'd0 : 2'd1;
    end
  end
  assign rgb = r_video ? r_pix : '0;
  assign game_begin = r_game_begin;
  assign game_over_display = r_over_disp;
  assign bg_sel = r_bg_sel;
  assign phase = r_phase;
endmodule

// File: doc/scene_compositor.md
# scene_compositor

Parametrised pixel compositor and game-phase sequencer for the VGA path. It merges `LAYERS` sprite/background planes by priority, with a transparency key and a runtime per-layer enable mask. It also owns the splash → play → game-over phase FSM and drives the background-source select used by the bitmap RAM mux. It sits between the layer engines (`cloud_bg`, `background_engine`, `object_engine` instances) and the `rgb` pins, and replaces the ad-hoc compositing and timer logic in the top level.

## Interface
- `LAYERS`, 5, number of input planes; index 0 = lowest priority.
- `COLOR_W`, 12, bits per pixel colour.
- `KEY_COLOR`, 12'hF0F, colour treated as transparent on any layer.
- `BG_COLOR`, 0, colour output when no layer is opaque during active video.
- `PLAY_ONLY_MASK`, 5'b00001, layers visible only in PLAY and OVER_WAIT.
- `SPLASH_CYCLES`, 500_000_000, SPLASH dwell in cycles (≥1).
- `GAMEOVER_CYCLES`, 5_000, OVER_WAIT dwell in cycles (≥1).

Ports:
- `clk` in 1: system clock. The block has one clock; reset is asynchronous and active-high.
- `clr` in 1: asynchronous active-high reset.
- `video_on` in 1: active-video flag, aligned with the layer inputs.
- `layer_on` in LAYERS: per-layer coverage flag.
- `rgb_pic` in LAYERS*COLOR_W: packed layer colours; layer i occupies bits [i*COLOR_W +: COLOR_W].
- `layer_en` in LAYERS: runtime enable mask; 0 hides the layer.
- `start` in 1: one-cycle pulse that skips the rest of SPLASH.
- `restart` in 1: one-cycle pulse that returns the FSM to SPLASH.
- `game_over` in 1: level from `game_engine`.
- `rgb` out COLOR_W: composited pixel.
- `game_begin` out 1: 1 in PLAY, OVER_WAIT and OVER_SHOW.
- `game_over_display` out 1: 1 in OVER_SHOW only.
- `bg_sel` out 2: background source select; 0 = splash, 1 = play bitmap, 2 = game-over bitmap.
- `phase` out 2: SPLASH=0, PLAY=1, OVER_WAIT=2, OVER_SHOW=3.

## Operation
- Reset values: `phase`=SPLASH, timer=0, `rgb`=0, `game_begin`=0, `game_over_display`=0, `bg_sel`=0, video pipeline flag=0.
- FSM transitions, evaluated each cycle:
  - `restart` has highest priority in every state: go to SPLASH and clear the timer.
  - SPLASH: the timer increments. Go to PLAY when `start`=1 or timer==SPLASH_CYCLES-1; timer←0 on the transition. `game_over` is ignored in SPLASH.
  - PLAY: go to OVER_WAIT when `game_over`=1; timer←0.
  - OVER_WAIT: the timer increments. Go to OVER_SHOW when timer==GAMEOVER_CYCLES-1. The state is sticky: deasserting `game_over` does not return the FSM to PLAY.
  - OVER_SHOW: hold until `restart`.
- `bg_sel` per phase: SPLASH→0, PLAY→1, OVER_WAIT→1, OVER_SHOW→2. Output flags are registered from the next state and change in the same edge as `phase`.
- Layer eligibility: layer i is eligible iff all of the following hold:
  - `layer_on[i]`=1 and `layer_en[i]`=1;
  - its colour ≠ KEY_COLOR;
  - if PLAY_ONLY_MASK[i]=1, the current phase is PLAY or OVER_WAIT.
- Pixel selection: the highest-index eligible layer wins. If no layer is eligible, output BG_COLOR.
- Blanking: when the delayed `video_on`=0, `rgb`=0 regardless of layer inputs.
- Timer: 32-bit unsigned. It never exceeds its limit and never wraps; it is held at 0 in PLAY and OVER_SHOW.

## Timing
- Pixel path latency is 1 cycle: inputs sampled at edge n appear on `rgb` after edge n.
- `video_on` is delayed 1 cycle internally so blanking stays aligned with pixel data.
- Phase gating for PLAY_ONLY layers uses the registered `phase` at the sampling edge.
- SPLASH→PLAY occurs exactly SPLASH_CYCLES edges after reset release, or 1 edge after `start` is sampled.
- OVER_WAIT→OVER_SHOW occurs GAMEOVER_CYCLES edges after entering OVER_WAIT.
- Asserting `clr` mid-frame forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- Parameters for all scenarios: SPLASH_CYCLES=4, GAMEOVER_CYCLES=3, LAYERS=5.
- Reset sequence: release `clr` and run idle → `phase`=0 for 4 cycles, then 1; `game_begin` rises on the same edge; `bg_sel` goes 0→1.
- Priority and transparency in PLAY:
  - layers 1, 2, 4 on; layer 4 colour = 12'hF0F; layer 2 = 12'h0A0 → `rgb`=12'h0A0 one cycle later;
  - clear `layer_en[2]` → layer 1's colour;
  - drop `video_on` → 0.
- PLAY_ONLY gating: in SPLASH, only layer 0 on with 12'h123 → `rgb`=BG_COLOR; in PLAY the same input → 12'h123.
- Game-over path:
  - `game_over`=1 in PLAY → `phase`=2 next edge with `bg_sel`=1;
  - after 3 more edges `phase`=3, `game_over_display`=1, `bg_sel`=2;
  - deassert `game_over` in OVER_WAIT → no change to the sequence.
- Start, restart and reset interaction:
  - `start` in SPLASH cycle 1 → PLAY next edge;
  - `restart` and `game_over` asserted together in PLAY → SPLASH;
  - async `clr` pulse mid-OVER_WAIT → `rgb`=0 and `phase`=0 before the next edge.
